// File: rtl/tqvp_matztron_trng_harvester.sv
// Harvests bytes from a TRNG peripheral and packs them little-endian into 32-bit words.
// A repetition health test trips the block into FAULT. Completed words leave through a 2-entry FWFT FIFO.
module tqvp_matztron_trng_harvester #(
  parameter int unsigned SAMPLE_DIV = 16,
  parameter int unsigned REP_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear_fail,
  output logic [3:0]  per_address,
  output logic        per_data_write,
  output logic [7:0]  per_data_in,
  input  logic [7:0]  per_data_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic        busy,
  output logic        health_fail
);

  typedef enum logic [2:0] {
    S_IDLE, S_ENABLE, S_WAIT, S_SAMPLE, S_DISABLE, S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  run_q, run_d;
  logic [7:0]  prev_q, prev_d;
  logic        first_q, first_d;
  logic [31:0] pack_q, pack_d;
  logic [1:0]  nbytes_q, nbytes_d;
  logic        held_q, held_d;
  logic        fail_q, fail_d;

  logic [31:0] fifo_q [2];
  logic        rdptr_q, wrptr_q;
  logic [1:0]  count_q;

  logic        push, pop, room;
  logic [31:0] push_data;
  logic [3:0]  run_next;
  logic        trip;

  assign pop      = (count_q != 2'd0) && word_ready;
  assign room     = (count_q != 2'd2) || pop;
  assign run_next = (first_q || (per_data_out != prev_q)) ? 4'd1 : run_q + 4'd1;
  assign trip     = (run_next == 4'(REP_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      run_q    <= '0;
      prev_q   <= '0;
      first_q  <= 1'b0;
      pack_q   <= '0;
      nbytes_q <= '0;
      held_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      prev_q   <= prev_d;
      first_q  <= first_d;
      pack_q   <= pack_d;
      nbytes_q <= nbytes_d;
      held_q   <= held_d;
      fail_q   <= fail_d;
    end
  end

  // A trip or a stop throws away the partial word and any completed word still waiting for FIFO space.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    run_d          = run_q;
    prev_d         = prev_q;
    first_d        = first_q;
    pack_d         = pack_q;
    nbytes_d       = nbytes_q;
    held_d         = held_q;
    fail_d         = fail_q;
    push           = 1'b0;
    push_data      = pack_q;
    per_address    = 4'd0;
    per_data_write = 1'b0;
    per_data_in    = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) state_d = S_ENABLE;
      end
      S_ENABLE: begin
        per_data_write = 1'b1;
        per_data_in    = 8'h01;
        first_d        = 1'b1;
        cnt_d          = 8'(SAMPLE_DIV - 1);
        state_d        = stop ? S_DISABLE : S_WAIT;
      end
      S_WAIT: begin
        if (stop) begin
          state_d  = S_DISABLE;
          pack_d   = '0;
          nbytes_d = '0;
          held_d   = 1'b0;
        end else begin
          if (held_q && room) begin
            push   = 1'b1;
            held_d = 1'b0;
            pack_d = '0;
          end
          if (cnt_q == 8'd0) begin
            if (!held_q) state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      S_SAMPLE: begin
        per_address = 4'd1;
        if (stop) begin
          state_d  = S_DISABLE;
          pack_d   = '0;
          nbytes_d = '0;
          held_d   = 1'b0;
        end else begin
          run_d   = run_next;
          prev_d  = per_data_out;
          first_d = 1'b0;
          if (trip) begin
            fail_d   = 1'b1;
            pack_d   = '0;
            nbytes_d = '0;
            state_d  = S_DISABLE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 8'(SAMPLE_DIV - 1);
            if (nbytes_q == 2'd3) begin
              nbytes_d = '0;
              if (room) begin
                push      = 1'b1;
                push_data = {per_data_out, pack_q[23:0]};
                pack_d    = '0;
              end else begin
                pack_d = {per_data_out, pack_q[23:0]};
                held_d = 1'b1;
              end
            end else begin
              pack_d[{nbytes_q, 3'b000} +: 8] = per_data_out;
              nbytes_d = nbytes_q + 2'd1;
            end
          end
        end
      end
      S_DISABLE: begin
        per_data_write = 1'b1;
        state_d        = fail_q ? S_FAULT : S_IDLE;
      end
      S_FAULT: begin
        if (clear_fail) begin
          fail_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rdptr_q   <= 1'b0;
      wrptr_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      if (push) begin
        fifo_q[wrptr_q] <= push_data;
        wrptr_q         <= ~wrptr_q;
      end
      if (pop) rdptr_q <= ~rdptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign word_valid  = (count_q != 2'd0);
  assign word_data   = word_valid ? fifo_q[rdptr_q] : 32'd0;
  assign busy        = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign health_fail = fail_q;

endmodule

// File: tb/tb_tqvp_matztron_trng_harvester.sv
// Scoreboard bench for the TRNG harvester: a byte-level reference model predicts packed words,
// and a negedge monitor compares every word the DUT hands out.
module tb_tqvp_matztron_trng_harvester;

  localparam int unsigned SAMPLE_DIV = 4;
  localparam int unsigned REP_LIMIT  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, clear_fail = 1'b0;
  logic [3:0]  per_address;
  logic        per_data_write;
  logic [7:0]  per_data_in;
  logic [7:0]  per_data_out = 8'h00;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic [31:0] word_data;
  logic        busy;
  logic        health_fail;

  tqvp_matztron_trng_harvester #(.SAMPLE_DIV(SAMPLE_DIV), .REP_LIMIT(REP_LIMIT)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear_fail(clear_fail),
    .per_address(per_address), .per_data_write(per_data_write), .per_data_in(per_data_in),
    .per_data_out(per_data_out), .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .busy(busy), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state: bytes accepted into the current word, run length, expected words.
  logic [7:0]  srcQ [$];
  logic [31:0] expQ [$];
  logic [7:0]  accBytes [$];
  logic [7:0]  prevByte;
  int          runLen;
  bit          modelFirst, active, modelFault, fixedMode;
  int          readCnt = 0, enCnt = 0, disCnt = 0;
  bit          stallPending = 0;
  logic [31:0] stallData;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelDiscard();
    accBytes.delete();
  endtask

  task automatic modelByte(input logic [7:0] b);
    logic [31:0] w;
    if (modelFirst || b != prevByte) runLen = 1;
    else runLen = runLen + 1;
    prevByte   = b;
    modelFirst = 0;
    if (runLen >= REP_LIMIT) begin
      accBytes.delete();
      modelFault = 1;
      active     = 0;
    end else begin
      accBytes.push_back(b);
      if (accBytes.size() == 4) begin
        w = 0;
        for (int i = 0; i < 4; i++) w = w + (32'(accBytes[i]) << (8 * i));
        expQ.push_back(w);
        accBytes.delete();
      end
    end
  endtask

  // Peripheral model: presents the head of srcQ, refilling with a byte unlike the last one shown.
  always @(posedge clk) begin
    logic [7:0] b;
    #1;
    if (fixedMode) per_data_out = 8'hA5;
    else begin
      if (srcQ.size() == 0) begin
        b = 8'($urandom);
        while (b == per_data_out) b = 8'($urandom);
        srcQ.push_back(b);
      end
      per_data_out = srcQ[0];
    end
  end

  // Monitor: values seen at a negedge are what the DUT acts on at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      accBytes.delete();
      active       = 0;
      modelFault   = 0;
      stallPending = 0;
    end else begin
      if (per_data_write) begin
        if (per_address == 4'd0 && per_data_in == 8'h01) enCnt++;
        else if (per_address == 4'd0 && per_data_in == 8'h00) disCnt++;
        else check("write_addr_data", {20'd0, per_address, per_data_in}, 32'h0);
      end
      if (stallPending) begin
        check("stall_valid", word_valid, 1);
        check("stall_data", word_data, stallData);
      end
      stallPending = word_valid && !word_ready;
      stallData    = word_data;
      if (word_valid && word_ready) begin
        if (expQ.size() == 0) check("unexpected_word", word_data, 32'hxxxxxxxx);
        else check("word", word_data, expQ.pop_front());
      end
      if (per_address == 4'd1 && !per_data_write) begin
        readCnt++;
        if (srcQ.size() != 0 && !fixedMode) void'(srcQ.pop_front());
        if (stop) modelDiscard();
        else modelByte(per_data_out);
      end
      if (stop && active) begin
        modelDiscard();
        active = 0;
      end
      if (start && !stop && !active && !modelFault) begin
        active     = 1;
        modelFirst = 1;
      end
      if (clear_fail && modelFault) modelFault = 0;
    end
  end

  task automatic applyStimulus(input int which);
    if (which == 0) start = 1;
    else if (which == 1) stop = 1;
    else if (which == 2) clear_fail = 1;
    else word_ready = 1;
    tick();
    if (which == 0) start = 0;
    else if (which == 1) stop = 0;
    else if (which == 2) clear_fail = 0;
    else word_ready = 0;
  endtask

  task automatic waitReads(input int target, input int budget, input string name);
    int n = 0;
    while (readCnt < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(readCnt >= target), 1);
  endtask

  task automatic checkOutput(input string name, input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, expQ.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_addr"}, per_address, 0);
    check({tag, "_wr"}, per_data_write, 0);
    check({tag, "_din"}, per_data_in, 0);
    check({tag, "_valid"}, word_valid, 0);
    check({tag, "_data"}, word_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fail"}, health_fail, 0);
  endtask

  initial begin
    int base, en0, dis0;
    fixedMode = 0;
    tick(); tick();
    checkAllZero("reset");
    rst = 0;
    tick();

    // Basic word assembly.
    srcQ.delete();
    srcQ = '{8'h11, 8'h22, 8'h33, 8'h44};
    word_ready = 1;
    tick();
    en0 = enCnt; base = readCnt;
    applyStimulus(0);
    waitReads(base + 4, 60, "basic_reads");
    checkOutput("basic_drain", 20);
    check("basic_enable_write", enCnt, en0 + 1);
    applyStimulus(1);
    tick(); tick();

    // Backpressure: two words fill the FIFO, the third is held, sampling stalls.
    srcQ.delete();
    for (int i = 1; i <= 12; i++) srcQ.push_back(8'(i));
    word_ready = 0;
    tick();
    base = readCnt;
    applyStimulus(0);
    waitReads(base + 12, 120, "bp_reads");
    repeat (40) tick();
    check("bp_no_more_reads", readCnt, base + 12);
    check("bp_valid", word_valid, 1);
    check("bp_head", word_data, 32'h04030201);
    applyStimulus(3);
    waitReads(base + 13, 30, "bp_resume");
    word_ready = 1;
    repeat (10) tick();
    applyStimulus(1);
    checkOutput("bp_drain", 20);
    tick(); tick();

    // Health test with a stuck byte.
    fixedMode = 1;
    tick();
    base = readCnt; dis0 = disCnt;
    applyStimulus(0);
    waitReads(base + 4, 60, "health_reads");
    tick(); tick();
    check("health_fail_set", health_fail, 32'(modelFault));
    check("health_disable_write", disCnt, dis0 + 1);
    check("health_busy", busy, 0);
    check("health_no_word", word_valid, 0);
    check("health_exp_empty", expQ.size(), 0);
    applyStimulus(0);
    tick();
    check("health_start_ignored", busy, 0);
    fixedMode = 0;
    applyStimulus(2);
    check("health_cleared", health_fail, 0);

    // Stop mid-word, then restart with fresh bytes.
    srcQ.delete();
    srcQ = '{8'hB1, 8'hB2, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    tick();
    base = readCnt; dis0 = disCnt;
    applyStimulus(0);
    waitReads(base + 2, 40, "stop_reads");
    applyStimulus(1);
    tick();
    check("stop_disable_write", disCnt, dis0 + 1);
    check("stop_busy", busy, 0);
    check("stop_no_word", word_valid, 0);
    applyStimulus(0);
    waitReads(base + 6, 60, "restart_reads");
    checkOutput("restart_drain", 20);
    applyStimulus(1);
    tick(); tick();

    // Start and stop together in IDLE does nothing.
    en0 = enCnt;
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    repeat (3) tick();
    check("startstop_no_enable", enCnt, en0);
    check("startstop_busy", busy, 0);

    // Randomized harvest with random backpressure.
    applyStimulus(0);
    for (int i = 0; i < 600; i++) begin
      word_ready = 1'($urandom_range(0, 1));
      tick();
    end
    word_ready = 1;
    repeat (10) tick();
    applyStimulus(1);
    checkOutput("random_drain", 30);
    tick(); tick();

    // Asynchronous reset during WAIT: no DISABLE write.
    dis0 = disCnt;
    applyStimulus(0);
    tick(); tick();
    #2 rst = 1;
    #1 checkAllZero("async_rst");
    tick(); tick();
    rst = 0;
    repeat (5) tick();
    check("rst_no_disable", disCnt, dis0);
    check("rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
